mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//  Multi-cycle sequencer for the RV32M mul/div/rem ops that the control decoder emits.
//  Sits beside the ALU in EX. It accepts one op, holds the pipeline via stall, and iterates
//  a shift-add multiplier or a restoring divider. It then returns a 32-bit result for one cycle.
// PARAMETERS
//  XLEN     32   operand/result width; iteration count = XLEN
// PORTS
//  clk        in   1     single clock; all state on rising edge
//  rst        in   1     synchronous, active-high reset
//  flush      in   1     pipeline flush; kills in-flight op
//  req_valid  in   1     EX holds a mul/div op; held stable until resp_valid
//  req_op     in   3     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 REM,6/7 illegal
//  req_a      in   XLEN  rs1 value (dividend / multiplicand)
//  req_b      in   XLEN  rs2 value (divisor / multiplier)
//  req_ready  out  1     high in IDLE only
//  stall      out  1     freeze IF/ID/EX while op outstanding
//  resp_valid out  1     one-cycle result pulse
//  resp_data  out  XLEN  result, valid when resp_valid
// BEHAVIOUR
//  States: IDLE, MUL, DIV, DONE. cnt counts 0..XLEN-1.
//  Reset: state=IDLE, cnt=0, resp_valid=0, resp_data=0, stall=0.
//  Accept: IDLE & req_valid & !flush in cycle T. Latch sign flags and |a|, |b|.
//   MUL: sign=a[31]^b[31]. MULH: same. MULHSU: sign=a[31], b taken unsigned.
//   MULHU: both unsigned. DIV/REM: signed.
//  Next state: MUL or DIV, cnt=0. Exceptions: fast-path cases and ops 6/7 go straight to DONE.
//  MUL: 64-bit acc += mcand<<cnt when mplier bit set. 32 iterations in T+1..T+32.
//   Then negate the 64-bit acc if sign. MUL returns low half; MULH/MULHSU/MULHU return high half.
//  DIV: unsigned restoring, 1 quotient bit/cycle, T+1..T+32.
//   Quotient is negated if the dividend and divisor signs differ (DIV only).
//   Remainder takes the dividend's sign.
//  DONE at T+33: resp_valid=1, resp_data driven; next state IDLE.
//  stall = (state!=IDLE & state!=DONE) | (state==IDLE & req_valid & !flush).
//   stall is low in DONE so the pipeline advances on the same edge it captures the result.
//  Fast paths: result registered in DONE at T+1, stall high in T only.
//   b==0: DIV result 0xFFFFFFFF; REM result a.
//   a==0x80000000 & b==0xFFFFFFFF: DIV result 0x80000000; REM result 0.
//   ops 6/7: result 0.
//  flush: from any state, next state IDLE with no resp_valid. flush beats req_valid in IDLE.
//   stall drops in the flush cycle.
//  rst mid-operation: same as flush plus resp_data cleared. There is no partial result.
//  req_a/req_b/req_op changes after acceptance are ignored (operands latched).
//  resp_data holds its last value outside DONE. resp_valid is 0 outside DONE.
//  Back-to-back: new req is accepted in the IDLE cycle right after DONE. Minimum spacing is 1 idle cycle.
//  Width rules: magnitude of 0x80000000 = 0x80000000 unsigned, with no overflow.
//   The accumulator is 64 bits. The remainder register is XLEN+1 bits for the trial subtract.
// CONFIGURATION
//  MDU_FAST_MUL_EN defined: MUL* ops use a single-cycle 64-bit signed/unsigned multiplier.
//   IDLE goes directly to DONE, result at T+1, and the MUL state is unused.
//  Undefined: iterative shift-add as above, latency T+33. Results are bit-identical in both builds.
// TESTING
//  DIV a=100 b=7 at T -> stall T..T+32, resp_valid at T+33 with 14; REM same -> 2.
//  DIV a=0xFFFFFFF9 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU-style op 6 -> 0 at T+1.
//  DIV a=5 b=0 -> 0xFFFFFFFF at T+1; REM a=5 b=0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
//  a=b=0xFFFFFFFF: MUL->1, MULH->0, MULHU->0xFFFFFFFE, MULHSU->0xFFFFFFFF.
//   Latency is T+33, or T+1 with MDU_FAST_MUL_EN.
//  DIV accepted at T, flush at T+10 -> no resp_valid, stall low at T+10, req_ready high T+11.
//   A new MUL at T+11 completes normally.
//  rst at T+5 of a DIV -> resp_valid stays 0, resp_data=0, IDLE at T+6.
//   Two back-to-back DIVs -> two single resp_valid pulses with the correct results.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M mul/div/rem sequencer: shift-add multiply, restoring divide.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a one-cycle product.
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            req_ready,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt;

  logic [2:0]        op;
  logic              neg;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplier, quo, rem, dvsr;
  logic [XLEN-1:0]   resp_q;

  logic            accept, last;
  logic            is_mul, is_div, illegal, fast;
  logic            a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  logic [2*XLEN-1:0] acc_nx, mul_fin;
  logic [XLEN:0]     shifted, diff;
  logic [XLEN-1:0]   rem_nx, quo_nx, div_sel, div_fin, iter_res;

  assign accept  = (state == IDLE) && req_valid && !flush;
  assign is_mul  = !req_op[2];
  assign is_div  = (req_op == 3'd4) || (req_op == 3'd5);
  assign illegal = (req_op[2:1] == 2'b11);

  // MULHU is fully unsigned; MULHSU only treats rs1 as signed.
  assign a_neg  = req_a[XLEN-1] && (req_op != 3'd3) && !illegal;
  assign b_neg  = req_b[XLEN-1] && (req_op != 3'd2) && (req_op != 3'd3) && !illegal;
  assign a_mag  = a_neg ? -req_a : req_a;
  assign b_mag  = b_neg ? -req_b : req_b;
  assign neg_in = (req_op == 3'd5) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    fast     = illegal;
    fast_res = '0;
    if (is_div && (req_b == '0)) begin
      fast     = 1'b1;
      fast_res = (req_op == 3'd4) ? '1 : req_a;
    end else if (is_div && (req_a == MIN) && (req_b == '1)) begin
      fast     = 1'b1;
      fast_res = (req_op == 3'd4) ? MIN : '0;
    end
`ifdef MDU_FAST_MUL_EN
    else if (is_mul) begin
      logic [2*XLEN-1:0] prod;
      prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
      if (neg_in) prod = -prod;
      fast     = 1'b1;
      fast_res = (req_op == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One multiplier bit / one quotient bit per cycle.
  assign acc_nx  = acc + (mplier[0] ? mcand : '0);
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr};
  assign rem_nx  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nx  = {quo[XLEN-2:0], !diff[XLEN]};

  assign mul_fin = neg ? -acc_nx : acc_nx;
  assign div_sel = (op == 3'd4) ? quo_nx : rem_nx;
  assign div_fin = neg ? -div_sel : div_sel;

  always_comb begin
    iter_res = div_fin;
    if (state == MUL)
      iter_res = (op == 3'd0) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
  end

  assign last = ((state == MUL) || (state == DIV)) && (cnt == CW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= ((state == MUL) || (state == DIV)) ? cnt + CW'(1) : '0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = fast ? DONE : (is_mul ? MUL : DIV);
      MUL:  if (last) state_nx = DONE;
      DIV:  if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_comb begin
    req_ready  = 1'b0;
    stall      = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid && !flush;
      end
      MUL:  stall = !flush;
      DIV:  stall = !flush;
      DONE: resp_valid = !flush;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op     <= req_op;
      neg    <= neg_in;
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, a_mag};
      mplier <= b_mag;
      quo    <= a_mag;
      dvsr   <= b_mag;
      rem    <= '0;
    end else if (state == MUL) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (state == DIV) begin
      rem <= rem_nx;
      quo <= quo_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      resp_q <= '0;
    else if (accept && fast)
      resp_q <= fast_res;
    else if (last && !flush)
      resp_q <= iter_res;
  end

  assign resp_data = resp_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Testbench for mdu_sequencer: directed RV32M cases plus random ops
// checked against an arithmetic reference model.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready, stall, resp_valid;
  logic [31:0] resp_data;

  int checks   = 0;
  int failures = 0;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  localparam logic [31:0] MIN = 32'h8000_0000;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .stall(stall),
    .resp_valid(resp_valid), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return ALL;
        if (a == MIN && b == ALL) return MIN;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return a;
        if (a == MIN && b == ALL) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (op >= 3'd6) return 1;
    if (op >= 3'd4 && (b == 0 || (a == MIN && b == ALL))) return 1;
    if (op < 3'd4 && FAST_MUL) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return ALL;
      3: return MIN;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    #1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(string tag, logic [2:0] op, logic [31:0] a, logic [31:0] b, bit scramble);
    int n;
    bit stall_ok;
    logic [31:0] e;
    e = ref_model(op, a, b);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    wait_ready();
    check({tag, "_rv_idle"}, 32'(resp_valid), 32'd0);
    check({tag, "_stall_T"}, 32'(stall), 32'd1);
    n = 0;
    stall_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (!resp_valid) begin
        if (!stall) stall_ok = 1'b0;
        if (scramble) begin
          req_a = $urandom;
          req_b = $urandom;
          req_op = 3'($urandom);
        end
      end
    end while (!resp_valid && n < 40);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat(op, a, b)));
    check({tag, "_stall_hold"}, 32'(stall_ok), 32'd1);
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    check({tag, "_data"}, resp_data, e);
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rv", 32'(resp_valid), 32'd0);
    check("rst_data", resp_data, 32'd0);
    rst = 1'b0;

    run_op("div_100_7", 3'd4, 32'd100, 32'd7, 1'b0);
    run_op("rem_100_7", 3'd5, 32'd100, 32'd7, 1'b0);
    run_op("div_neg7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_neg7_2", 3'd5, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("op6", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("op7", 3'd7, 32'h1234_5678, 32'd9, 1'b0);
    run_op("div_by0", 3'd4, 32'd5, 32'd0, 1'b0);
    run_op("rem_by0", 3'd5, 32'd5, 32'd0, 1'b0);
    run_op("div_ovf", 3'd4, MIN, ALL, 1'b0);
    run_op("rem_ovf", 3'd5, MIN, ALL, 1'b0);
    run_op("mul_m1", 3'd0, ALL, ALL, 1'b0);
    run_op("mulh_m1", 3'd1, ALL, ALL, 1'b0);
    run_op("mulhu_m1", 3'd3, ALL, ALL, 1'b0);
    run_op("mulhsu_m1", 3'd2, ALL, ALL, 1'b0);
    run_op("mulh_min", 3'd1, MIN, MIN, 1'b0);

    req_valid = 1'b1;
    req_op = 3'd4;
    req_a = 32'd100;
    req_b = 32'd7;
    wait_ready();
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_rv", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_ready", 32'(req_ready), 32'd1);
    check("flush_rv_after", 32'(resp_valid), 32'd0);
    run_op("mul_after_flush", 3'd0, 32'd12345, 32'd678, 1'b0);

    run_op("div_before_rst", 3'd4, 32'd100, 32'd7, 1'b0);
    req_valid = 1'b1;
    req_op = 3'd4;
    req_a = 32'd1000;
    req_b = 32'd3;
    wait_ready();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_ready", 32'(req_ready), 32'd1);
    check("mrst_rv", 32'(resp_valid), 32'd0);
    check("mrst_data", resp_data, 32'd0);
    @(posedge clk); #1;
    check("mrst_rv2", 32'(resp_valid), 32'd0);

    run_op("b2b_div1", 3'd4, 32'd99991, 32'd17, 1'b0);
    run_op("b2b_div2", 3'd4, 32'hFFFF_0000, 32'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
